if_stage: RTL and testbench

//  Instruction-fetch stage: the producer of the IF/ID interface the decode stage reads.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/if_stage.sv | 149 ++++++++++++++
 tb/tb_if_stage.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: default widths, canonical NOP, RV32 opcodes and field positions.
package cpu_pkg;

  localparam int unsigned D_WIDTH_DEF = 32;
  localparam int unsigned A_WIDTH_DEF = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;

  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned FUNCT7_LSB = 25;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: synchronous FIFO of {pc, instr} pairs with flush, occupancy count and async reset.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned A_WIDTH = A_WIDTH_DEF,
  parameter int unsigned D_WIDTH = D_WIDTH_DEF,
  parameter int unsigned DEPTH   = 2,
  localparam int unsigned PW     = $clog2(DEPTH),
  localparam int unsigned CW     = PW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               push_i,
  input  logic [A_WIDTH-1:0] push_pc_i,
  input  logic [D_WIDTH-1:0] push_data_i,
  input  logic               pop_i,
  output logic [A_WIDTH-1:0] head_pc_o,
  output logic [D_WIDTH-1:0] head_data_o,
  output logic [CW-1:0]      count_o,
  output logic               empty_o
);

  logic [A_WIDTH+D_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]              count_q;
  logic                       do_push, do_pop;

  // Clear wins over a simultaneous push or pop.
  assign do_push = push_i && !clear_i;
  assign do_pop  = pop_i && !clear_i && (count_q != '0);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= {push_pc_i, push_data_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign {head_pc_o, head_data_o} = mem_q[rd_ptr_q];
  assign count_o                  = count_q;
  assign empty_o                  = (count_q == '0);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order imem requests,
// buffers responses and drives the IF/ID register with decoded RV32 fields.
module if_stage
  import cpu_pkg::*;
#(
  parameter int unsigned        D_WIDTH    = D_WIDTH_DEF,
  parameter int unsigned        A_WIDTH    = A_WIDTH_DEF,
  parameter int unsigned        RF_SIZE    = 5,
  parameter int unsigned        FIFO_DEPTH = 2,
  parameter logic [A_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               redirect,
  input  logic [A_WIDTH-1:0] redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [A_WIDTH-1:0] imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [D_WIDTH-1:0] imem_rsp_data,
  output logic               instr_valid,
  output logic [A_WIDTH-1:0] pc_id,
  output logic [D_WIDTH-1:0] instr,
  output logic [6:0]         opcode,
  output logic [RF_SIZE-1:0] rd,
  output logic [2:0]         funct3,
  output logic [RF_SIZE-1:0] rs1,
  output logic [RF_SIZE-1:0] rs2,
  output logic [6:0]         funct7
);

  localparam int unsigned        CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned        OW      = CW + 1;
  localparam logic [OW-1:0]      CREDITS = OW'(FIFO_DEPTH);
  localparam logic [D_WIDTH-1:0] NOP     = D_WIDTH'(NOP_INSTR);

  logic [A_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [A_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [A_WIDTH-1:0] pc_id_q, pc_id_d;
  logic [D_WIDTH-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic [CW-1:0]      in_flight_q, in_flight_d;
  logic [CW-1:0]      drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;
  logic [A_WIDTH-1:0] head_pc;
  logic [D_WIDTH-1:0] head_data;
  logic [OW-1:0]      occupancy;
  logic               credit_ok, req_fire, rsp_keep, fifo_pop;

  // Outstanding plus buffered never exceeds FIFO_DEPTH, so the buffer cannot overflow.
  assign occupancy      = {1'b0, in_flight_q} + {1'b0, fifo_count};
  assign credit_ok      = occupancy < CREDITS;
  assign imem_req_valid = !rst && !redirect && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && !redirect && (drop_cnt_q == '0);
  assign fifo_pop       = en && !redirect && !fifo_empty;

  fetch_fifo #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (redirect),
    .push_i      (rsp_keep),
    .push_pc_i   (rsp_pc_q),
    .push_data_i (imem_rsp_data),
    .pop_i       (fifo_pop),
    .head_pc_o   (head_pc),
    .head_data_o (head_data),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    pc_id_d       = pc_id_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    drop_cnt_d    = drop_cnt_q;
    in_flight_d   = in_flight_q + CW'(req_fire) - CW'(imem_rsp_valid);

    if (redirect) begin
      // Everything still outstanding after this cycle's response belongs to the old path.
      fetch_pc_d    = redirect_pc;
      rsp_pc_d      = redirect_pc;
      drop_cnt_d    = in_flight_q - CW'(imem_rsp_valid);
      instr_d       = NOP;
      instr_valid_d = 1'b0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + A_WIDTH'(4);
      end
      if (rsp_keep) begin
        rsp_pc_d = rsp_pc_q + A_WIDTH'(4);
      end
      if (imem_rsp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (en) begin
        if (!fifo_empty) begin
          instr_d       = head_data;
          pc_id_d       = head_pc;
          instr_valid_d = 1'b1;
        end else begin
          instr_d       = NOP;
          instr_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      pc_id_q       <= '0;
      instr_q       <= NOP;
      instr_valid_q <= 1'b0;
      in_flight_q   <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      pc_id_q       <= pc_id_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      in_flight_q   <= in_flight_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign instr_valid = instr_valid_q;
  assign pc_id       = pc_id_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[OPCODE_LSB +: 7];
  assign rd          = instr_q[RD_LSB +: RF_SIZE];
  assign funct3      = instr_q[FUNCT3_LSB +: 3];
  assign rs1         = instr_q[RS1_LSB +: RF_SIZE];
  assign rs2         = instr_q[RS2_LSB +: RF_SIZE];
  assign funct7      = instr_q[FUNCT7_LSB +: 7];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: field-decode vector table plus hand-written stall,
// redirect, random-handshake, wrap and async-reset sequences against an in-order memory model.
module tb_if_stage;
  import cpu_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic [31:0] pc_id;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;

  if_stage #(
    .D_WIDTH    (32),
    .A_WIDTH    (32),
    .RF_SIZE    (5),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .pc_id          (pc_id),
    .instr          (instr),
    .opcode         (opcode),
    .rd             (rd),
    .funct3         (funct3),
    .rs1            (rs1),
    .rs2            (rs2),
    .funct7         (funct7)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } req_t;

  vec_t        tbl [8];
  req_t        pq [$];
  logic [31:0] acc_log [$];
  int          n_vec = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned n_acc = 0;
  int unsigned n_load = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_req = '0;

  // Low addresses hold the decode table; everything else is an address-derived pattern.
  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a < 32'd32) return tbl[a[4:2]].instr;
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"},  {31'b0, instr_valid}, 32'd0);
    chk({tag, "_instr"},  instr, NOP_INSTR);
    chk({tag, "_pc_id"},  pc_id, 32'd0);
    chk({tag, "_reqv"},   {31'b0, imem_req_valid}, 32'd0);
    chk({tag, "_opcode"}, {25'b0, opcode}, 32'h13);
    chk({tag, "_fields"}, {rd, funct3, rs1, rs2, funct7}, 32'd0);
  endtask

  // One clock: memory drives its due response, request handshake is recorded,
  // then after the edge every IF/ID load is checked against the expected PC stream.
  task automatic tick();
    logic        en_s, rd_s;
    logic [31:0] rpc_s;
    int unsigned d;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memword(pq[0].addr);
      void'(pq.pop_front());
    end
    #1;
    en_s  = en;
    rd_s  = redirect;
    rpc_s = redirect_pc;
    if (rd_s) chk("no_req_on_redirect", {31'b0, imem_req_valid}, 32'd0);
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr_seq", imem_req_addr, exp_req);
      exp_req = exp_req + 32'd4;
      d = cyc + lat;
      if (pq.size() > 0 && pq[$].due >= d) d = pq[$].due + 1;
      pq.push_back('{addr: imem_req_addr, due: d});
      acc_log.push_back(imem_req_addr);
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rd_s) begin
      exp_pc  = rpc_s;
      exp_req = rpc_s;
      chk("redirect_bubble_valid", {31'b0, instr_valid}, 32'd0);
      chk("redirect_bubble_instr", instr, NOP_INSTR);
    end else if (en_s && instr_valid) begin
      chk("load_pc", pc_id, exp_pc);
      chk("load_instr", instr, memword(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_load++;
    end
  endtask

  task automatic wait_valid(input string name, input int unsigned budget);
    int unsigned k = 0;
    while (!instr_valid && k < budget) begin
      tick();
      k++;
    end
    chk(name, {31'b0, instr_valid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] s_instr, s_pc;
    logic        s_valid;
    int unsigned base;
    logic        found;

    tbl[0] = '{32'h0020_81B3, 7'h33, 5'd3,  3'd0, 5'd1,  5'd2,  7'h00};
    tbl[1] = '{32'h4000_0033, 7'h33, 5'd0,  3'd0, 5'd0,  5'd0,  7'h20};
    tbl[2] = '{32'hFFF0_0093, 7'h13, 5'd1,  3'd0, 5'd0,  5'd31, 7'h7F};
    tbl[3] = '{32'h0000_0013, 7'h13, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00};
    tbl[4] = '{32'hFFFF_FFFF, 7'h7F, 5'd31, 3'd7, 5'd31, 5'd31, 7'h7F};
    tbl[5] = '{32'h00A5_2423, 7'h23, 5'd8,  3'd2, 5'd10, 5'd10, 7'h00};
    tbl[6] = '{32'h8000_0000, 7'h00, 5'd0,  3'd0, 5'd0,  5'd0,  7'h40};
    tbl[7] = '{32'h0000_F000, 7'h00, 5'd0,  3'd7, 5'd1,  5'd0,  7'h00};

    // Reset values
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    en = 1'b1;
    imem_req_ready = 1'b1;
    lat = 1;

    // Back-to-back stream from 0, field decode table
    wait_valid("t1_first_valid", 10);
    for (int i = 0; i < 8; i++) begin
      chk("t1_valid",  {31'b0, instr_valid}, 32'd1);
      chk("t1_pc_id",  pc_id, 32'(i * 4));
      chk("t1_opcode", {25'b0, opcode}, {25'b0, tbl[i].op});
      chk("t1_rd",     {27'b0, rd},     {27'b0, tbl[i].rd});
      chk("t1_funct3", {29'b0, funct3}, {29'b0, tbl[i].f3});
      chk("t1_rs1",    {27'b0, rs1},    {27'b0, tbl[i].rs1});
      chk("t1_rs2",    {27'b0, rs2},    {27'b0, tbl[i].rs2});
      chk("t1_funct7", {25'b0, funct7}, {25'b0, tbl[i].f7});
      tick();
    end

    // Decode stall: outputs frozen, credit fully used, stream resumes in order
    en = 1'b0;
    s_instr = instr;
    s_pc    = pc_id;
    s_valid = instr_valid;
    repeat (5) begin
      tick();
      chk("t2_frozen_instr", instr, s_instr);
      chk("t2_frozen_pc",    pc_id, s_pc);
      chk("t2_frozen_valid", {31'b0, instr_valid}, {31'b0, s_valid});
    end
    chk("t2_outstanding", n_acc - n_load, DEPTH);
    en = 1'b1;
    base = n_load;
    repeat (12) tick();
    chk("t2_resume_progress", {31'b0, (n_load - base) >= 10}, 32'd1);

    // Redirect with two requests in flight at latency 3
    lat = 3;
    repeat (12) tick();
    imem_req_ready = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (pq.size() == 2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("t3_two_in_flight", {31'b0, found}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect       = 1'b0;
    imem_req_ready = 1'b1;
    wait_valid("t3_valid_after_redirect", 20);
    chk("t3_pc_id", pc_id, 32'h0000_0100);

    // Random ready and latency 1..4, random decode stalls
    base = n_load;
    for (int k = 0; k < 300; k++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      lat            = $urandom_range(1, 4);
      en             = ($urandom_range(0, 3) != 0);
      tick();
    end
    en = 1'b1;
    imem_req_ready = 1'b1;
    lat = 1;
    repeat (10) tick();
    chk("t4_progress", {31'b0, (n_load - base) >= 40}, 32'd1);

    // Redirect coinciding with a response while decode is stalled
    imem_req_ready = 1'b0;
    repeat (8) tick();
    chk("t5_drained", pq.size(), 32'd0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    imem_req_ready = 1'b1;
    tick();
    chk("t5_pre_valid", {31'b0, instr_valid}, 32'd1);
    chk("t5_rsp_pending", pq.size(), 32'd1);
    en             = 1'b0;
    imem_req_ready = 1'b0;
    redirect       = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    chk("t5_rsp_was_delivered", pq.size(), 32'd0);
    redirect       = 1'b0;
    en             = 1'b1;
    imem_req_ready = 1'b1;
    wait_valid("t5_valid_after_redirect", 10);
    chk("t5_pc_id", pc_id, 32'h0000_0200);

    // PC wrap at the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    acc_log.delete();
    repeat (4) tick();
    if (acc_log.size() >= 2) begin
      chk("t6_wrap_first", acc_log[0], 32'hFFFF_FFFC);
      chk("t6_wrap_next",  acc_log[1], 32'h0000_0000);
    end else begin
      chk("t6_wrap_req_count", acc_log.size(), 32'd2);
    end

    // Asynchronous reset mid-cycle
    #3 rst = 1'b1;
    imem_rsp_valid = 1'b0;
    pq.delete();
    #1;
    chk_reset("async_rst");
    @(posedge clk);
    #1;
    chk_reset("rst_held");
    rst     = 1'b0;
    exp_pc  = '0;
    exp_req = '0;
    wait_valid("t6_valid_after_rst", 10);
    chk("t6_pc_after_rst", pc_id, 32'h0000_0000);
    chk("t6_instr_after_rst", instr, 32'h0020_81B3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
